// File: rtl/rca_add_scheduler_pkg.sv
// Shared definitions for the time-multiplexed 64-bit adder: FSM encoding,
// default geometry and a configuration check for the operand/slice split.
package rca_add_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_W     = 64;
  localparam int DEF_SLICE = 32;

  // The shared slice is a fixed 32-bit RCA and the operand must be exactly two slices.
  function automatic bit slice_cfg_ok(input int w, input int slice);
    return (slice == 32) && (w == 2 * slice);
  endfunction

endpackage

// File: rtl/rca_add_scheduler_if.sv
// Request/response bundle between the requesters and the shared adder.
// Handshake: a request is taken on a clock edge where req_valid[i] and
// req_ready[i] are both high; a result is taken on an edge where rsp_valid
// and rsp_ready are both high. A requester keeps its operands stable while
// its valid is high and ready is low; rsp_* stay stable while rsp_valid is
// high and rsp_ready is low.
interface rca_add_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 64
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ready;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
endinterface

// File: rtl/RCA32.sv
// 32-bit ripple-carry adder slice shared by the scheduler.
module RCA32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carryInput,
  output logic [31:0] sum,
  output logic        carryOutput
);
  logic carry;

  // Bit-serial ripple: each stage consumes the previous stage's carry.
  always_comb begin
    sum   = '0;
    carry = carryInput;
    for (int i = 0; i < 32; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    carryOutput = carry;
  end
endmodule

// File: rtl/rca_add_scheduler_rr_arbiter.sv
// Round-robin pick: first valid requester at or above rr_ptr, wrapping.
module rca_add_scheduler_rr_arbiter
  import rca_add_scheduler_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IDW-1:0]  rr_ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            any_o
);
  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_o && req_valid_i[(int'(rr_ptr_i) + k) % NREQ]) begin
        any_o                                 = 1'b1;
        grant_o[(int'(rr_ptr_i) + k) % NREQ] = 1'b1;
        grant_idx_o                           = IDW'((int'(rr_ptr_i) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/rca_add_scheduler.sv
// Shares one 32-bit ripple-carry slice among NREQ requesters to perform
// 64-bit adds: low half in LO, high half in HI with the carry held in
// carry_q between them, result presented in RESP.
module rca_add_scheduler
  import rca_add_scheduler_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int W     = DEF_W,
  parameter int SLICE = DEF_SLICE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rca_add_scheduler_if.slave   bus,
  output state_e               state_o
);
  localparam int IDW = $clog2(NREQ);

  if (!slice_cfg_ok(W, SLICE)) begin : g_cfg_err
    $error("rca_add_scheduler: W must be 2*SLICE with SLICE=32");
  end

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q;
  logic [W-1:0]     a_q, b_q;
  logic             cin_q;
  logic [IDW-1:0]   id_q;
  logic [SLICE-1:0] lo_q;
  logic             carry_q;
  logic [W-1:0]     sum_q;
  logic             cout_q;
  logic [IDW-1:0]   rsp_id_q;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic             accept;

  logic [SLICE-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cin, slice_cout;

  rca_add_scheduler_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_valid_i (bus.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  // Requests are only offered in IDLE; reset also masks the strobe so all
  // outputs read 0 while rst_n is low.
  assign accept        = rst_n && (state_q == ST_IDLE) && grant_any;
  assign bus.req_ready = accept ? grant : '0;

  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_id    = rsp_id_q;
  assign state_o       = state_q;

  // Slice input mux: low halves with the request carry-in, or high halves
  // with the carry registered out of the low half.
  always_comb begin
    if (state_q == ST_HI) begin
      slice_a   = a_q[W-1:SLICE];
      slice_b   = b_q[W-1:SLICE];
      slice_cin = carry_q;
    end else begin
      slice_a   = a_q[SLICE-1:0];
      slice_b   = b_q[SLICE-1:0];
      slice_cin = cin_q;
    end
  end

  RCA32 u_slice (
    .a           (slice_a),
    .b           (slice_b),
    .carryInput  (slice_cin),
    .sum         (slice_sum),
    .carryOutput (slice_cout)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: fixed IDLE -> LO -> HI -> RESP -> IDLE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_LO;
      ST_LO:   state_d = ST_HI;
      ST_HI:   state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, half results and pointer update. The visible result
  // registers change only when the high half completes, so rsp_* keep the
  // previous result until the next one is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      id_q     <= '0;
      lo_q     <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      rsp_id_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q      <= bus.req_a[int'(grant_idx)*W +: W];
            b_q      <= bus.req_b[int'(grant_idx)*W +: W];
            cin_q    <= bus.req_cin[grant_idx];
            id_q     <= grant_idx;
            rr_ptr_q <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
          end
        end
        ST_LO: begin
          lo_q    <= slice_sum;
          carry_q <= slice_cout;
        end
        ST_HI: begin
          sum_q    <= {slice_sum, lo_q};
          cout_q   <= slice_cout;
          rsp_id_q <= id_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rca_add_scheduler.sv
// Bench for rca_add_scheduler: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// transaction-level model (round-robin choice, fixed 3-cycle result delay,
// full-width a+b+cin arithmetic).
module tb_rca_add_scheduler;
  import rca_add_scheduler_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 64;
  localparam int IDW  = 2;
  localparam int EW   = 1 + W + IDW;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_e state;

  always #5 clk = ~clk;

  rca_add_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

  rca_add_scheduler #(.NREQ(NREQ), .W(W), .SLICE(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting on the DUT at %0t", name, $time);
  endtask

  // ---------------- scoreboard / model ----------------
  // One add is in flight at most; the result appears 3 cycles after the
  // accept cycle and remains until the consumer takes it.
  bit               m_busy = 0;
  int               m_age  = 0;
  int               m_rr   = 0;
  logic [W-1:0]     m_last_sum  = '0;
  logic             m_last_cout = 1'b0;
  logic [IDW-1:0]   m_last_id   = '0;
  logic [EW-1:0]    exp_q[$];
  bit               m_acc_valid = 0;
  int               m_acc_id    = 0;

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] e_rdy;
    logic            e_vld;
    logic [W-1:0]    e_sum;
    logic            e_cout;
    logic [IDW-1:0]  e_id;
    logic [W:0]      full;
    int              g;
    #1;
    e_rdy = '0;
    g     = -1;
    if (rst_n && !m_busy)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && bus.req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
    if (g >= 0) e_rdy[g] = 1'b1;
    e_vld = rst_n && m_busy && (m_age == 3);
    if (!rst_n)     {e_cout, e_sum, e_id} = '0;
    else if (e_vld) {e_cout, e_sum, e_id} = exp_q[0];
    else            {e_cout, e_sum, e_id} = {m_last_cout, m_last_sum, m_last_id};

    check("req_ready", bus.req_ready, e_rdy);
    check("rsp_valid", bus.rsp_valid, e_vld);
    check("rsp_sum",   bus.rsp_sum,   e_sum);
    check("rsp_cout",  bus.rsp_cout,  e_cout);
    check("rsp_id",    bus.rsp_id,    e_id);

    m_acc_valid = 0;
    if (!rst_n) begin
      m_busy = 0; m_age = 0; m_rr = 0;
      m_last_sum = '0; m_last_cout = 1'b0; m_last_id = '0;
      exp_q.delete();
    end else if (m_busy) begin
      if (m_age == 3) begin
        if (bus.rsp_ready) begin
          {m_last_cout, m_last_sum, m_last_id} = exp_q.pop_front();
          m_busy = 0;
        end
      end else begin
        m_age++;
      end
    end else if (g >= 0) begin
      full = {1'b0, bus.req_a[g*W +: W]} + {1'b0, bus.req_b[g*W +: W]} + (W+1)'(bus.req_cin[g]);
      exp_q.push_back({full[W], full[W-1:0], IDW'(g)});
      m_busy = 1; m_age = 1;
      m_rr = (g + 1) % NREQ;
      m_acc_valid = 1; m_acc_id = g;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.req_valid[i]    = 1'b1;
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_cin[i]      = cin;
  endtask

  // Returns at the negedge opening the cycle after the accept (LO).
  task automatic wait_accept(input int id, input string name);
    bit seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (m_acc_valid && m_acc_id == id) seen = 1;
    end
    if (!seen) fail_timeout(name);
  endtask

  task automatic wait_rsp(input string name);
    bit seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk); #2;
      if (bus.rsp_valid) seen = 1;
    end
    if (!seen) fail_timeout(name);
  endtask

  task automatic do_add(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] x_sum, input logic x_cout, input string name);
    @(negedge clk);
    set_req(id, a, b, cin);
    wait_accept(id, name);
    bus.req_valid[id] = 1'b0;
    @(negedge clk); #2;
    check({name, "_vld_hi"}, bus.rsp_valid, 0);
    @(negedge clk); #2;
    check({name, "_vld"},  bus.rsp_valid, 1);
    check({name, "_sum"},  bus.rsp_sum,   x_sum);
    check({name, "_cout"}, bus.rsp_cout,  x_cout);
    check({name, "_id"},   bus.rsp_id,    id);
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check({name, "_vld"},   bus.rsp_valid, 0);
    check({name, "_sum"},   bus.rsp_sum,   0);
    check({name, "_cout"},  bus.rsp_cout,  0);
    check({name, "_id"},    bus.rsp_id,    0);
    check({name, "_rdy"},   bus.req_ready, 0);
    check({name, "_state"}, state,         ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return '1;
      1:       return '0;
      2:       return {32'h0, 32'hFFFF_FFFF};
      3:       return {$urandom, 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int            fair_exp [5];
    logic [IDW-1:0] got_id  [5];
    logic [W-1:0]   got_sum [5];
    int            got;
    fair_exp = '{0, 1, 2, 3, 0};

    idle_inputs();
    rst_n = 1'b0;
    bus.req_valid[1] = 1'b1;          // must not be strobed while in reset
    @(negedge clk); @(negedge clk); #2;
    check("reset_rdy",   bus.req_ready, 0);
    check("reset_vld",   bus.rsp_valid, 0);
    check("reset_sum",   bus.rsp_sum,   0);
    check("reset_cout",  bus.rsp_cout,  0);
    check("reset_id",    bus.rsp_id,    0);
    check("reset_state", state,         ST_IDLE);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;

    do_add(0, 64'd5, 64'd7, 1'b0, 64'd12, 1'b0, "basic");
    do_add(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, "cross");
    do_add(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, "wrap");
    do_add(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, "msb_ovf");

    // Fairness from a fresh pointer with every requester continuously valid.
    pulse_reset("rst_pulse");
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_req(i, {32'(i + 1), 32'hFFFF_FFFF}, 64'd1, 1'b0);
    got = 0;
    for (int n = 0; n < 60 && got < 5; n++) begin
      @(negedge clk); #2;
      if (bus.rsp_valid) begin
        got_id[got]  = bus.rsp_id;
        got_sum[got] = bus.rsp_sum;
        got++;
        if (got == 5) bus.req_valid = 4'b0100;
      end
    end
    if (got < 5) fail_timeout("fair_collect");
    for (int k = 0; k < got; k++) check($sformatf("fair_id%0d", k), got_id[k], fair_exp[k]);
    if (got > 0) check("fair_sum0", got_sum[0], 64'h0000_0002_0000_0000);

    // Only requester 2 left after grant 0: served next.
    wait_rsp("lone2");
    check("lone2_id",  bus.rsp_id,  2);
    check("lone2_sum", bus.rsp_sum, 64'h0000_0004_0000_0000);
    bus.req_valid = '0;

    // Backpressure: result held, no new grant while stalled.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    set_req(1, 64'h1234, 64'h1, 1'b1);
    wait_accept(1, "bp_accept");
    bus.req_valid[1] = 1'b0;
    set_req(3, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0);
    @(negedge clk); @(negedge clk); #2;
    check("bp_first_vld", bus.rsp_valid, 1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); #2;
      check("bp_vld", bus.rsp_valid, 1);
      check("bp_sum", bus.rsp_sum,   64'h1236);
      check("bp_id",  bus.rsp_id,    1);
      check("bp_rdy", bus.req_ready, 0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #2;
    check("bp_rel_vld", bus.rsp_valid, 1);
    @(negedge clk); #2;
    check("bp_next_rdy", bus.req_ready, 4'b1000);
    check("bp_next_vld", bus.rsp_valid, 0);
    @(negedge clk);
    bus.req_valid = '0;
    wait_rsp("bp_req3");
    check("bp_req3_id",   bus.rsp_id,   3);
    check("bp_req3_sum",  bus.rsp_sum,  64'd0);
    check("bp_req3_cout", bus.rsp_cout, 1);

    // Reset while the high half is being computed.
    @(negedge clk);
    set_req(0, 64'hAAAA, 64'h5555, 1'b0);
    wait_accept(0, "mid_accept");
    bus.req_valid = 4'b0100;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("mid_rst_vld",   bus.rsp_valid, 0);
    check("mid_rst_sum",   bus.rsp_sum,   0);
    check("mid_rst_cout",  bus.rsp_cout,  0);
    check("mid_rst_id",    bus.rsp_id,    0);
    check("mid_rst_rdy",   bus.req_ready, 0);
    check("mid_rst_state", state,         ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = '0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk); #2;
      check("mid_no_rsp", bus.rsp_valid, 0);
    end
    do_add(3, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 64'h1234_5678_9ABC_DF01, 1'b0, "after_rst");

    // Randomized traffic with occasional resets and consumer stalls.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst_n         = ($urandom_range(0, 299) != 0);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (m_acc_valid && m_acc_id == i) begin
          if ($urandom_range(0, 1) == 1) set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
          else bus.req_valid[i] = 1'b0;
        end else if (bus.req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        end
      end
    end

    // Drain whatever is in flight.
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 10; n++) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
